dm_stage_memory: RTL and testbench
==================================

Name: dm_stage_memory

Overview:
- Data memory for the M pipeline stage.
- Consumes the MemWrite strobe from the M-stage controller, plus the M-stage ALU address and store data.
- Performs synchronous word/half/byte stores and combinational loads with sign or zero extension.
- Detects misaligned and out-of-range accesses, suppresses faulting stores, and keeps a sticky error flag for the exception logic.

Parameters:
- ADDR_WIDTH, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KB).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mem_write  input  1  store strobe from the M-stage controller (high for sw/sh/sb).
- mem_read  input  1  load request; qualifies rdata and error checking.
- width  input  2  access size: 00 word, 01 half, 10 byte, 11 reserved.
- load_unsigned  input  1  1 = zero-extend half/byte loads, 0 = sign-extend.
- addr  input  32  byte address from the M-stage ALU result.
- wdata  input  32  store data; low bits are used for half/byte stores.
- pc  input  32  PC of the M-stage instruction; used only by the optional log.
- rdata  output  32  load result (combinational).
- addr_err  output  1  current access faults (combinational).
- err_sticky  output  1  latched once any faulting access has occurred.

Behaviour:
- Address decode:
  - off = addr - BASE_ADDR (32-bit wrap); idx = off[ADDR_WIDTH+1:2].
  - Out of range when off[31:ADDR_WIDTH+2] != 0.
- addr_err = (mem_write | mem_read) & (out_of_range | misaligned | width==11).
  - Misaligned: word with addr[1:0]!=0, or half with addr[0]!=0.
  - addr_err is 0 when neither mem_write nor mem_read is asserted.
- Byte lanes are little-endian: byte lane k = mem[idx][8k+7:8k], k = addr[1:0]. Half lane h = addr[1], bits 16h+15:16h.
- Store, on rising clk when mem_write=1, addr_err=0 and reset=0:
  - Word: writes wdata.
  - Half: writes wdata[15:0] into lane h.
  - Byte: writes wdata[7:0] into lane k.
  - Other lanes are unchanged.
  - Faulting stores leave the array untouched.
- Load is combinational from the current array contents:
  - Word: mem[idx].
  - Half/byte: the selected lane, extended to 32 bits per load_unsigned.
  - rdata = 0 when mem_read=0 or addr_err=1.
- Read during write to the same word: rdata shows the pre-edge contents, and the new value is visible after the edge. There is no internal forwarding.
- err_sticky:
  - Set on a rising clk when addr_err=1.
  - Cleared only by reset.
  - Once set it stays high (saturates) under further faults.
- Reset (asynchronous):
  - All words cleared to 0 and err_sticky cleared to 0 immediately on assertion.
  - Stores are ignored while reset is high.
  - Reset asserted mid-stream discards the edge-coincident store.
- Latency: stores take effect 1 cycle after the edge (visible from the next cycle); loads take 0 cycles.
- Back-to-back stores every cycle are supported with no stall.

Optional Feature:
- Macro DM_WRITE_LOG_EN.
- When defined: each committed store prints one simulation line in the form "<time>@<pc>: *<word-aligned byte address> <= <full 32-bit word after merge>". The address printed is BASE_ADDR + idx*4.
- Faulting stores instead print "<time>@<pc>: DM fault addr=<addr>".
- When undefined: no print statements are compiled, and the functional behaviour is identical.

Test Plan:
- Reset, then sw addr=0x0000_0010 wdata=0xDEADBEEF; next cycle lw addr=0x10 -> rdata=0xDEADBEEF, addr_err=0, err_sticky=0.
- Over word 0x10 = 0xDEADBEEF, sb addr=0x12 wdata=0x000000AA, then lw 0x10 -> 0xDEAABEEF. Then lb 0x12 signed -> 0xFFFFFFAA; lbu 0x12 -> 0x000000AA.
- sh addr=0x22 wdata=0x8001, then lh 0x22 -> 0xFFFF8001; lhu 0x22 -> 0x00008001; lw 0x20 -> 0x80010000.
- Misaligned and out-of-range faults:
  - sw addr=0x0000_0006 -> addr_err=1, word 0x04 unchanged, err_sticky=1 after the edge.
  - sw addr=0x0000_1000 (ADDR_WIDTH=10) -> addr_err=1, no write; word 0 is still 0 (no aliasing).
- Same-cycle sw 0x30=0x11111111 with lw 0x30 (prior value 0x0) -> rdata=0x0 that cycle, 0x11111111 the next cycle.
- Write 0x55 to word 0x40, then assert reset mid-cycle with mem_write=1 pending -> rdata of lw 0x40 = 0 after reset, and err_sticky=0.

Source files
------------

// File: rtl/dm_stage_memory.sv
// rtl/dm_stage_memory.sv - M-stage data memory: byte/half/word stores, extended loads, fault detection (optional store log: DM_WRITE_LOG_EN)
module dm_stage_memory #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  width,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        err_sticky
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;

  logic [31:0]           mem_q [DEPTH];
  logic                  err_sticky_q;
  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  out_of_range;
  logic                  misaligned;
  logic [31:0]           cur_word;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [31:0]           word_d;
  logic                  store_en;
  logic                  unused_ok;

  assign off          = addr - BASE_ADDR;
  assign idx          = off[ADDR_WIDTH+1:2];
  assign out_of_range = |off[31:ADDR_WIDTH+2];
  assign cur_word     = mem_q[idx];
  assign store_en     = mem_write & ~addr_err;
  assign err_sticky   = err_sticky_q;
  // pc is only consumed by the optional store log; low offset bits select lanes via addr
  assign unused_ok    = ^{pc, off[1:0]};

  // Fault detection and load path: pick the lane, extend, gate with read/fault
  always_comb begin
    misaligned = 1'b0;
    case (width)
      W_WORD:  misaligned = (addr[1:0] != 2'b00);
      W_HALF:  misaligned = addr[0];
      default: misaligned = 1'b0;
    endcase
    addr_err = (mem_write | mem_read) & (out_of_range | misaligned | (width == 2'b11));
    sel_byte = cur_word[8*addr[1:0] +: 8];
    sel_half = addr[1] ? cur_word[31:16] : cur_word[15:0];
    rdata    = 32'h0;
    if (mem_read && !addr_err) begin
      case (width)
        W_WORD:  rdata = cur_word;
        W_HALF:  rdata = load_unsigned ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
        W_BYTE:  rdata = load_unsigned ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
        default: rdata = 32'h0;
      endcase
    end
  end

  // Store merge: replace only the addressed lane(s) of the current word
  always_comb begin
    word_d = cur_word;
    case (width)
      W_WORD: word_d = wdata;
      W_HALF: begin
        if (addr[1]) word_d[31:16] = wdata[15:0];
        else         word_d[15:0]  = wdata[15:0];
      end
      W_BYTE:  word_d[8*addr[1:0] +: 8] = wdata[7:0];
      default: word_d = cur_word;
    endcase
  end

  // Array and sticky fault flag; reset wipes contents and drops any coincident store
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
      err_sticky_q <= 1'b0;
    end else begin
      if (store_en) mem_q[idx] <= word_d;
      if (addr_err) err_sticky_q <= 1'b1;
    end
  end

`ifdef DM_WRITE_LOG_EN
  // Simulation trace of committed and faulting stores
  always @(posedge clk) begin
    if (!reset && mem_write) begin
      if (addr_err) $display("%0t@%h: DM fault addr=%h", $time, pc, addr);
      else $display("%0t@%h: *%h <= %h", $time, pc, BASE_ADDR + {{(30-ADDR_WIDTH){1'b0}}, idx, 2'b00}, word_d);
    end
  end
`endif

endmodule

// File: tb/tb_dm_stage_memory.sv
// tb/tb_dm_stage_memory.sv - randomized self-checking bench for dm_stage_memory against a byte-array model
module tb_dm_stage_memory;

  localparam int          AW    = 10;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          BYTES = 4 << AW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [1:0]  width = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] pc = 32'h0;
  logic [31:0] rdata;
  logic        addr_err;
  logic        err_sticky;

  dm_stage_memory #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .width(width), .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
    .pc(pc), .rdata(rdata), .addr_err(addr_err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // reference model: flat little-endian byte memory plus a sticky bit
  logic [7:0]  mb [BYTES];
  logic        m_sticky;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] obs_rd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_fault(bit mw, bit mr, logic [1:0] w, logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    if (!(mw || mr)) return 1'b0;
    if (o >= BYTES) return 1'b1;
    if (w == 2'd3) return 1'b1;
    if (w == 2'd0 && a[1:0] != 2'd0) return 1'b1;
    if (w == 2'd1 && a[0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(bit mw, bit mr, logic [1:0] w, bit lu, logic [31:0] a);
    int o;
    logic [15:0] h;
    logic [7:0]  b;
    if (!mr || m_fault(mw, mr, w, a)) return 32'h0;
    o = int'(a - BASE);
    case (w)
      2'd0: return {mb[o+3], mb[o+2], mb[o+1], mb[o]};
      2'd1: begin
        h = {mb[o+1], mb[o]};
        return lu ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: begin
        b = mb[o];
        return lu ? {24'h0, b} : {{24{b[7]}}, b};
      end
    endcase
  endfunction

  task automatic m_clear();
    for (int i = 0; i < BYTES; i++) mb[i] = 8'h0;
    m_sticky = 1'b0;
  endtask

  // one access cycle: drive after negedge, check combinational outputs, then commit model at posedge
  task automatic access(input bit mw, input bit mr, input logic [1:0] w, input bit lu,
                        input logic [31:0] a, input logic [31:0] wd);
    bit f;
    int o;
    @(negedge clk);
    mem_write = mw; mem_read = mr; width = w; load_unsigned = lu; addr = a; wdata = wd;
    pc = pc + 32'd4;
    #1;
    f = m_fault(mw, mr, w, a);
    obs_rd = rdata;
    check_val("rdata", rdata, m_read(mw, mr, w, lu, a));
    check_val("addr_err", {31'h0, addr_err}, {31'h0, f});
    check_val("err_sticky", {31'h0, err_sticky}, {31'h0, m_sticky});
    @(posedge clk);
    if (f) m_sticky = 1'b1;
    if (mw && !f) begin
      o = int'(a - BASE);
      case (w)
        2'd0: for (int k = 0; k < 4; k++) mb[o+k] = wd[8*k +: 8];
        2'd1: begin mb[o] = wd[7:0]; mb[o+1] = wd[15:8]; end
        default: mb[o] = wd[7:0];
      endcase
    end
  endtask

  // reset pulse asserted mid-cycle with a store pending across the edge
  task automatic pulse_reset(input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    mem_write = 1'b1; mem_read = 1'b0; width = 2'd0; addr = a; wdata = wd;
    #2 reset = 1'b1;
    #1;
    check_val("rst_sticky_async", {31'h0, err_sticky}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_write = 1'b0;
    m_clear();
  endtask

  initial begin
    m_clear();
    // reset state
    #2;
    check_val("reset_sticky", {31'h0, err_sticky}, 32'h0);
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h0;
    #1 check_val("reset_rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mem_read = 1'b0;

    // directed plan
    access(1, 0, 2'd0, 0, 32'h10, 32'hDEADBEEF);
    access(0, 1, 2'd0, 0, 32'h10, 32'h0);
    check_val("plan_lw10", obs_rd, 32'hDEADBEEF);
    access(1, 0, 2'd2, 0, 32'h12, 32'h000000AA);
    access(0, 1, 2'd0, 0, 32'h10, 32'h0);
    check_val("plan_sb_merge", obs_rd, 32'hDEAABEEF);
    access(0, 1, 2'd2, 0, 32'h12, 32'h0);
    check_val("plan_lb", obs_rd, 32'hFFFFFFAA);
    access(0, 1, 2'd2, 1, 32'h12, 32'h0);
    check_val("plan_lbu", obs_rd, 32'h000000AA);
    access(1, 0, 2'd1, 0, 32'h22, 32'h00008001);
    access(0, 1, 2'd1, 0, 32'h22, 32'h0);
    check_val("plan_lh", obs_rd, 32'hFFFF8001);
    access(0, 1, 2'd1, 1, 32'h22, 32'h0);
    check_val("plan_lhu", obs_rd, 32'h00008001);
    access(0, 1, 2'd0, 0, 32'h20, 32'h0);
    check_val("plan_lw20", obs_rd, 32'h80010000);
    access(1, 0, 2'd0, 0, 32'h6, 32'h12345678);
    access(0, 1, 2'd0, 0, 32'h4, 32'h0);
    check_val("plan_misaligned_nowrite", obs_rd, 32'h0);
    check_val("plan_sticky_set", {31'h0, err_sticky}, 32'h1);
    access(1, 0, 2'd0, 0, 32'h1000, 32'hCAFEF00D);
    access(0, 1, 2'd0, 0, 32'h0, 32'h0);
    check_val("plan_no_alias", obs_rd, 32'h0);
    access(1, 1, 2'd0, 0, 32'h30, 32'h11111111);
    check_val("plan_rdw_old", obs_rd, 32'h0);
    access(0, 1, 2'd0, 0, 32'h30, 32'h0);
    check_val("plan_rdw_new", obs_rd, 32'h11111111);
    access(1, 0, 2'd0, 0, 32'h40, 32'h00000055);
    pulse_reset(32'h40, 32'h000000AA);
    access(0, 1, 2'd0, 0, 32'h40, 32'h0);
    check_val("plan_reset_wipe", obs_rd, 32'h0);
    check_val("plan_reset_sticky", {31'h0, err_sticky}, 32'h0);

    // randomized traffic concentrated on a small window, with occasional far addresses and resets
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 79) == 0) begin
        pulse_reset($urandom_range(0, 127), $urandom);
      end else begin
        if ($urandom_range(0, 15) == 0) a = $urandom;
        else a = $urandom_range(0, 127);
        access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
